// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: state encodings, oversample
// default, shift register reset value and the parity helper.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    localparam int         OVERSAMPLE_DFT = 16;
    localparam logic [7:0] DATA_REG_DFT   = 8'h00;

    // even = 1 gives a bit that makes the data plus parity have even weight
    function automatic logic parity_bit(input logic [7:0] data, input logic even);
        return even ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register for uart_tx: byte, frame config and precomputed
// parity. Only present when UART_TX_HOLD_EN is defined.
`ifdef UART_TX_HOLD_EN
module uart_tx_hold
    import uart_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       wr,
    input  logic [7:0] wr_data,
    input  logic       wr_no_parity,
    input  logic       wr_ev_parity,
    input  logic       pop,
    output logic       full,
    output logic [7:0] data,
    output logic       par,
    output logic       no_par
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            full   <= 1'b0;
            data   <= DATA_REG_DFT;
            par    <= 1'b0;
            no_par <= 1'b1;
        end else if (wr) begin
            full   <= 1'b1;
            data   <= wr_data;
            par    <= parity_bit(wr_data, wr_ev_parity);
            no_par <= wr_no_parity;
        end else if (pop) begin
            full   <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, one stop.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DFT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_data_sample,
    input  logic       tx_en,
    input  logic       no_parity,
    input  logic       ev_parity,
    input  logic       wr_data_flag,
    input  logic [7:0] txd_in,
    output logic       txd,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overrun,
    output tx_state_t  state
);

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    tx_state_t  state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d, no_par_q, no_par_d;
    logic       txd_d, done_d;
    logic       tx_pos, accept, bit_end, stop_end, frame_start;
    logic       src_valid, load, load_par, load_no_par;
    logic [7:0] load_data;

    // Handshake: a write is taken in any clk where wr_data_flag and tx_ready are
    // both high; wr_data_flag with tx_ready low is dropped and flagged by tx_overrun.
    assign tx_pos      = tx_en & tx_data_sample;
    assign accept      = wr_data_flag & tx_ready;
    assign bit_end     = tx_pos & (tick_q == TICK_LAST);
    assign stop_end    = (state_q == TX_STOP) & bit_end;
    assign frame_start = src_valid & (((state_q == TX_IDLE) & tx_pos) | stop_end);
    assign tx_busy     = (state_q != TX_IDLE);
    assign state       = state_q;

`ifdef UART_TX_HOLD_EN
    logic       hold_full, hold_par, hold_no_par, bypass;
    logic [7:0] hold_data;

    // A write landing on the last stop tick goes straight into the shifter
    assign bypass      = stop_end & accept;
    assign tx_ready    = tx_en & ~hold_full & ~rst;
    assign src_valid   = hold_full | bypass;
    assign load        = frame_start;
    assign load_data   = hold_full ? hold_data : txd_in;
    assign load_par    = hold_full ? hold_par : parity_bit(txd_in, ev_parity);
    assign load_no_par = hold_full ? hold_no_par : no_parity;

    uart_tx_hold u_hold (
        .clk          (clk),
        .rst          (rst),
        .clr          (~tx_en),
        .wr           (accept & ~bypass),
        .wr_data      (txd_in),
        .wr_no_parity (no_parity),
        .wr_ev_parity (ev_parity),
        .pop          (frame_start & hold_full),
        .full         (hold_full),
        .data         (hold_data),
        .par          (hold_par),
        .no_par       (hold_no_par)
    );
`else
    logic pending_q;

    assign tx_ready    = tx_en & (state_q == TX_IDLE) & ~pending_q & ~rst;
    assign src_valid   = pending_q;
    assign load        = accept;
    assign load_data   = txd_in;
    assign load_par    = parity_bit(txd_in, ev_parity);
    assign load_no_par = no_parity;

    always_ff @(posedge clk) begin
        if (rst || !tx_en)    pending_q <= 1'b0;
        else if (accept)      pending_q <= 1'b1;
        else if (frame_start) pending_q <= 1'b0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        no_par_d = no_par_q;
        done_d   = 1'b0;
        if (load) begin
            shift_d  = load_data;
            par_d    = load_par;
            no_par_d = load_no_par;
        end
        if (tx_pos && state_q != TX_IDLE) tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
        unique case (state_q)
            TX_IDLE:   if (frame_start) state_d = TX_START;
            TX_START:  if (bit_end) begin
                state_d = TX_DATA;
                bit_d   = 3'd0;
            end
            TX_DATA:   if (bit_end) begin
                shift_d = {1'b0, shift_q[7:1]};
                if (bit_q == 3'd7) state_d = no_par_q ? TX_STOP : TX_PARITY;
                else               bit_d   = bit_q + 3'd1;
            end
            TX_PARITY: if (bit_end) state_d = TX_STOP;
            TX_STOP:   if (bit_end) begin
                done_d  = 1'b1;
                state_d = frame_start ? TX_START : TX_IDLE;
            end
            default:   state_d = TX_IDLE;
        endcase
        if (!tx_en) begin
            state_d = TX_IDLE;
            tick_d  = 4'd0;
            bit_d   = 3'd0;
            done_d  = 1'b0;
        end
    end

    // Line level follows the next state so txd changes on the same edge as the FSM
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shift_d[0];
            TX_PARITY: txd_d = par_d;
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            tick_q     <= 4'd0;
            bit_q      <= 3'd0;
            shift_q    <= DATA_REG_DFT;
            par_q      <= 1'b0;
            no_par_q   <= 1'b1;
            txd        <= 1'b1;
            tx_done    <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            no_par_q   <= no_par_d;
            txd        <= txd_d;
            tx_done    <= done_d;
            tx_overrun <= wr_data_flag & ~tx_ready;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; covers the holding-register
// variant as well when UART_TX_HOLD_EN is defined.
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int OS = 16;

    logic       clk, rst, tx_data_sample, tx_en, no_parity, ev_parity, wr_data_flag;
    logic [7:0] txd_in;
    logic       txd, tx_ready, tx_busy, tx_done, tx_overrun;
    tx_state_t  state;

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   d0;
    logic obs_txd, obs_done, obs_busy;
    logic exp_q[$];

    uart_tx #(.OVERSAMPLE(OS)) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_data_sample (tx_data_sample),
        .tx_en          (tx_en),
        .no_parity      (no_parity),
        .ev_parity      (ev_parity),
        .wr_data_flag   (wr_data_flag),
        .txd_in         (txd_in),
        .txd            (txd),
        .tx_ready       (tx_ready),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_overrun     (tx_overrun),
        .state          (state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (tx_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one tick: sample outputs just after the tick edge, then one quiet clk
    task automatic tick();
        tx_data_sample = 1'b1;
        @(posedge clk); #1;
        obs_txd  = txd;
        obs_done = tx_done;
        obs_busy = tx_busy;
        tx_data_sample = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic np, input logic ev, input logic with_tick);
        txd_in = d; no_parity = np; ev_parity = ev;
        wr_data_flag = 1'b1; tx_data_sample = with_tick;
        check("ready_at_write", tx_ready, 1'b1);
        @(posedge clk); #1;
        wr_data_flag = 1'b0; tx_data_sample = 1'b0;
        check("idle_after_accept", state, TX_IDLE);
        check("line_after_accept", txd, 1'b1);
    endtask

    task automatic push_frame(input logic [7:0] d, input logic has_par, input logic par);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (has_par) exp_q.push_back(par);
        exp_q.push_back(1'b1);
    endtask

    task automatic try_write(input logic [7:0] d);
        txd_in = d;
`ifdef UART_TX_HOLD_EN
        check("hold_ready_mid_frame", tx_ready, 1'b1);
        wr_data_flag = 1'b1;
        @(posedge clk); #1;
        wr_data_flag = 1'b0;
        check("hold_no_overrun", tx_overrun, 1'b0);
`else
        check("busy_not_ready", tx_ready, 1'b0);
        wr_data_flag = 1'b1;
        @(posedge clk); #1;
        wr_data_flag = 1'b0;
        check("overrun_pulse", tx_overrun, 1'b1);
        @(posedge clk); #1;
        check("overrun_one_clk", tx_overrun, 1'b0);
`endif
    endtask

    task automatic run_bits(input string tag, input int nbits, input int fbits,
                            input int inject_at, input logic [7:0] inject_data);
        logic cur;
        cur = 1'b1;
        for (int t = 0; t < nbits * OS; t++) begin
            tick();
            if (t % OS == 0) cur = exp_q.pop_front();
            check({tag, "_txd"}, obs_txd, cur);
            check({tag, "_busy"}, obs_busy, 1'b1);
            check({tag, "_done"}, obs_done, (t > 0 && t % (fbits * OS) == 0));
            if (t == 50) begin
                ev_parity = ~ev_parity;
                no_parity = ~no_parity;
            end
            if (t == inject_at) try_write(inject_data);
        end
    endtask

    task automatic end_frame(input string tag);
        tick();
        check({tag, "_end_done"}, obs_done, 1'b1);
        check({tag, "_end_busy"}, obs_busy, 1'b0);
        check({tag, "_end_txd"}, obs_txd, 1'b1);
        check({tag, "_done_one_clk"}, tx_done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; tx_en = 1'b1; tx_data_sample = 1'b0; no_parity = 1'b1;
        ev_parity = 1'b1; wr_data_flag = 1'b0; txd_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_txd", txd, 1'b1);
        check("reset_ready", tx_ready, 1'b0);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        check("reset_overrun", tx_overrun, 1'b0);
        check("reset_state", state, TX_IDLE);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", tx_ready, 1'b1);

        // 0x55 no parity, with a tick in the accept cycle that must not start it
        write_byte(8'h55, 1'b1, 1'b0, 1'b1);
        push_frame(8'h55, 1'b0, 1'b0);
        run_bits("f55", 10, 10, -1, 8'h00);
        end_frame("f55");

        // 0xA3 even parity -> parity bit 0
        write_byte(8'hA3, 1'b0, 1'b1, 1'b0);
        push_frame(8'hA3, 1'b1, 1'b0);
        run_bits("fa3_even", 11, 11, -1, 8'h00);
        end_frame("fa3_even");

        // 0xA3 odd parity -> parity bit 1; config inputs toggle mid-frame
        write_byte(8'hA3, 1'b0, 1'b0, 1'b0);
        push_frame(8'hA3, 1'b1, 1'b1);
        run_bits("fa3_odd", 11, 11, -1, 8'h00);
        end_frame("fa3_odd");

        // abort at tick 40 of a 0xFF frame
        write_byte(8'hFF, 1'b1, 1'b0, 1'b0);
        repeat (40) tick();
        check("abort_busy_before", tx_busy, 1'b1);
        d0 = done_cnt;
        tx_en = 1'b0;
        @(posedge clk); #1;
        check("abort_txd", txd, 1'b1);
        check("abort_busy", tx_busy, 1'b0);
        check("abort_ready", tx_ready, 1'b0);
        check("abort_state", state, TX_IDLE);
        repeat (20) tick();
        check("abort_no_done", done_cnt, d0);
        tx_en = 1'b1;
        @(posedge clk); #1;
        check("reenable_ready", tx_ready, 1'b1);
        // 0x3C has four ones -> odd parity bit 1
        write_byte(8'h3C, 1'b0, 1'b0, 1'b0);
        push_frame(8'h3C, 1'b1, 1'b1);
        run_bits("f3c", 11, 11, -1, 8'h00);
        end_frame("f3c");

        // write during a frame
`ifdef UART_TX_HOLD_EN
        write_byte(8'h12, 1'b1, 1'b0, 1'b0);
        push_frame(8'h12, 1'b0, 1'b0);
        push_frame(8'h34, 1'b0, 1'b0);
        run_bits("b2b", 20, 10, 30, 8'h34);
        end_frame("b2b");
`else
        write_byte(8'h12, 1'b1, 1'b0, 1'b0);
        push_frame(8'h12, 1'b0, 1'b0);
        run_bits("ovr", 10, 10, 30, 8'h34);
        end_frame("ovr");
        repeat (20) tick();
        check("ovr_byte_lost", tx_busy, 1'b0);
        check("ovr_line_idle", txd, 1'b1);
`endif

        // reset in the middle of a start bit
        write_byte(8'hC3, 1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        check("pre_reset_start_bit", txd, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_txd", txd, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_done", tx_done, 1'b0);
        check("midrst_overrun", tx_overrun, 1'b0);
        check("midrst_ready", tx_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready_after", tx_ready, 1'b1);
        write_byte(8'h00, 1'b1, 1'b0, 1'b0);
        push_frame(8'h00, 1'b0, 1'b0);
        run_bits("f00", 10, 10, -1, 8'h00);
        end_frame("f00");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
